// File: rtl/uart_rx.sv
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1-style UART receiver, mid-bit sampling, valid/ack hand-off
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int BAUD      = 9600,
  parameter int SYS_CLK   = 12000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rx_wire,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = SYS_CLK / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       C_IDX_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       C_IDX_ONE  = 4'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [3:0]             idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   rx_meta_q;
  logic                   rx_s_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic                   frame_error_q;
  logic                   overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      rx_meta_q     <= rx_wire;
      rx_s_q        <= rx_meta_q;
      frame_error_q <= 1'b0;

      // Ack clears first; a load later in this block overrides it in the same cycle.
      if (rx_ack) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (enable && !rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          if (cnt_q == C_CNT_HALF) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + C_CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt_q == C_CNT_FULL) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            idx_q   <= idx_q + C_IDX_ONE;
            if (idx_q == C_IDX_LAST) begin
              state_q <= S_STOP;
            end
          end else begin
            cnt_q <= cnt_q + C_CNT_ONE;
          end
        end
        S_STOP: begin
          if (cnt_q == C_CNT_FULL) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            if (rx_s_q) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              if (rx_valid_q && !rx_ack) begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_error_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + C_CNT_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : self-checking bench for uart_rx (16 clk/bit, 8 data bits)
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

  localparam int C_BIT = 16;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       enable  = 1'b1;
  logic       rx_wire = 1'b1;
  logic       rx_ack  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  uart_rx #(.DATA_BITS(8), .BAUD(1), .SYS_CLK(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .rx_wire    (rx_wire),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_error(frame_error),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: what the consumer should see after each whole frame.
  logic [7:0] m_data  = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ov    = 1'b0;
  int         m_fe    = 0;

  int fe_seen = 0;
  int fe_long = 0;
  bit fe_prev = 1'b0;

  always @(negedge clk) begin
    if (frame_error === 1'b1) begin
      fe_seen++;
      if (fe_prev) fe_long++;
    end
    fe_prev = (frame_error === 1'b1);
  end

  task automatic model_frame(input logic [7:0] d, input bit good, input bit bad, input bit ack_same);
    bit prev;
    prev = m_valid;
    if (ack_same) begin
      m_valid = 1'b0;
      m_ov    = 1'b0;
    end
    if (good) begin
      if (prev && !ack_same) m_ov = 1'b1;
      m_valid = 1'b1;
      m_data  = d;
    end
    if (bad) m_fe++;
  endtask

  // en_mode: 0 enabled, 1 disabled whole frame, 2 dropped after the start bit.
  // ack_stop pulses rx_ack on the cycle whose rising edge samples the stop bit.
  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit ack_stop,
                            input int en_mode, input int rst_at);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int c = 0; c < 10 * C_BIT; c++) begin
      rx_wire = bits[c / C_BIT];
      rx_ack  = ack_stop && (c == 154);
      enable  = (en_mode == 1) ? 1'b0 : (en_mode == 2) ? (c < 40) : 1'b1;
      rst     = (rst_at >= 0) && (c >= rst_at) && (c < rst_at + 2);
      @(negedge clk);
    end
    rx_ack = 1'b0;
    enable = 1'b1;
    if (rst_at >= 0) begin
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_ov    = 1'b0;
    end else begin
      model_frame(d, (en_mode != 1) && stop_bit, (en_mode != 1) && !stop_bit, ack_stop);
    end
  endtask

  task automatic idle_gap(input int n, input bit ack);
    rx_wire = 1'b1;
    rx_ack  = ack;
    @(negedge clk);
    rx_ack = 1'b0;
    repeat (n) @(negedge clk);
    if (ack) begin
      m_valid = 1'b0;
      m_ov    = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(rx_valid), 32'(m_valid));
    check({tag, ".data"},  32'(rx_data),  32'(m_data));
    check({tag, ".ovr"},   32'(overrun),  32'(m_ov));
    check({tag, ".fe"},    32'(fe_seen),  32'(m_fe));
    check({tag, ".busy"},  32'(busy),     32'd0);
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input bit stop_bit, input bit ack_stop,
                       input int en_mode, input int rst_at, input int gap, input bit gap_ack);
    send_frame(d, stop_bit, ack_stop, en_mode, rst_at);
    idle_gap(gap, gap_ack);
    check_all(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    bit         sb;
    bit         ak;
    int         em;
    int         r;

    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    idle_gap(5, 1'b0);

    frame("a5", 8'hA5, 1'b1, 1'b0, 0, -1, 20, 1'b0);
    idle_gap(5, 1'b1);
    check_all("ack_a5");

    // Short low pulse: START is entered, then rejected at mid start bit.
    rx_wire = 1'b0;
    repeat (4) @(negedge clk);
    rx_wire = 1'b1;
    @(negedge clk);
    check("glitch.busy_hi", 32'(busy), 32'd1);
    idle_gap(20, 1'b0);
    check_all("glitch");

    frame("bad_stop", 8'h3C, 1'b0, 1'b0, 0, -1, 20, 1'b0);

    frame("f11", 8'h11, 1'b1, 1'b0, 0, -1, 20, 1'b0);
    frame("f22", 8'h22, 1'b1, 1'b0, 0, -1, 20, 1'b0);
    idle_gap(5, 1'b1);
    check_all("ack_ovr");

    frame("rst_mid", 8'hFF, 1'b1, 1'b0, 0, 88, 20, 1'b0);
    frame("f5a", 8'h5A, 1'b1, 1'b0, 0, -1, 20, 1'b1);

    frame("en_off", 8'h77, 1'b1, 1'b0, 1, -1, 20, 1'b0);
    frame("en_mid", 8'h77, 1'b1, 1'b0, 2, -1, 20, 1'b0);

    frame("f12", 8'h12, 1'b1, 1'b0, 0, -1, 20, 1'b0);
    frame("ack_load", 8'h99, 1'b1, 1'b1, 0, -1, 20, 1'b0);

    // Break: 464 clk low covers three full frame periods, the fourth start is rejected.
    rx_wire = 1'b0;
    repeat (464) @(negedge clk);
    m_fe += 3;
    idle_gap(30, 1'b0);
    check_all("break");

    for (int i = 0; i < 30; i++) begin
      d  = 8'($urandom);
      sb = ($urandom % 6) != 0;
      ak = ($urandom % 5) == 0;
      r  = int'($urandom % 8);
      em = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      if (em == 1) sb = 1'b1;
      frame($sformatf("rnd%0d", i), d, sb, ak, em, -1, 16 + int'($urandom % 16), ($urandom % 3) == 0);
    end

    check("fe_width", 32'(fe_long), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, payload bits per frame, legal 5..9.
REQ-002 SHALL have parameter BAUD, default 9600, bit rate in bits/s.
REQ-003 SHALL have parameter SYS_CLK, default 12000000, clk frequency in Hz; CLKS_PER_BIT = SYS_CLK/BAUD (integer), legal >= 4; HALF_BIT = CLKS_PER_BIT/2.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge, single clock domain.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port enable  input  1  permits start of new frame reception.
REQ-007 SHALL have port rx_wire  input  1  serial line, asynchronous to clk, idle high.
REQ-008 SHALL have port rx_ack  input  1  consumer accepts rx_data this cycle.
REQ-009 SHALL have port rx_data  output  DATA_BITS  last correctly framed payload.
REQ-010 SHALL have port rx_valid  output  1  rx_data holds unconsumed data.
REQ-011 SHALL have port frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 SHALL have port overrun  output  1  sticky: unconsumed data was overwritten.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL pass rx_wire through a 2-flop synchronizer (reset value 1); FSM uses only synchronized rx (rx_s).
REQ-015 SHALL implement states IDLE, START, DATA, STOP with one bit-timing counter (width clog2(CLKS_PER_BIT)) and 4-bit bit index.
REQ-016 IDLE: if enable==1 and rx_s==0 -> START, counter=0; otherwise stay.
REQ-017 START: counter increments per clk; at counter==HALF_BIT-1: rx_s==0 -> DATA, counter=0, index=0; rx_s==1 -> IDLE (glitch rejected, no output change).
REQ-018 DATA: at counter==CLKS_PER_BIT-1, sample rx_s into shift register LSB-first (first data bit -> bit 0), counter=0, index+1; after DATA_BITS samples -> STOP.
REQ-019 STOP: at counter==CLKS_PER_BIT-1 sample rx_s, then -> IDLE same edge.
REQ-020 Stop sample 1: next cycle rx_data = shift register, rx_valid=1.
REQ-021 Stop sample 0: next cycle frame_error=1 for exactly one cycle; rx_data, rx_valid unchanged.
REQ-022 rx_valid SHALL remain 1 and rx_data stable until a cycle with rx_ack==1; rx_valid then clears next cycle; rx_ack with rx_valid==0 ignored.
REQ-023 New good frame while rx_valid==1 and rx_ack==0: rx_data overwritten, rx_valid stays 1, overrun set.
REQ-024 New good frame in same cycle as rx_ack: new data loaded, rx_valid stays 1, overrun not set.
REQ-025 overrun SHALL clear on a cycle with rx_ack==1 (unless REQ-023 sets it same cycle; set wins).
REQ-026 enable deassert SHALL only block IDLE->START; a frame in progress completes normally.
REQ-027 Line held low (break): each frame period yields frame_error pulse; no rx_valid.
REQ-028 Latency: rx_wire falling edge to START entry = 2-3 clk (synchronizer); stop-sample edge to rx_valid = 1 clk.

Reset
REQ-029 rst==1 SHALL immediately force IDLE, counter=0, index=0, shift register=0, synchronizer=1, rx_data=0, rx_valid=0, frame_error=0, overrun=0, busy=0.
REQ-030 Reset mid-frame SHALL discard the partial frame; reception resumes on the next start bit after rst deasserts.

Verification (SYS_CLK=16, BAUD=1 -> CLKS_PER_BIT=16, HALF_BIT=8, DATA_BITS=8)
REQ-031 Frame 0,1,0,1,0,0,1,0,1,1 (start, 8'hA5 LSB-first, stop), 16 clk/bit -> rx_data=8'hA5, rx_valid=1, frame_error=0, overrun=0.
REQ-032 rx_wire low for 4 clk then high -> no state beyond START, rx_valid=0, busy returns 0.
REQ-033 Frame 8'h3C with stop bit 0 -> frame_error one-cycle pulse, rx_valid stays 0, rx_data unchanged.
REQ-034 Frames 8'h11 then 8'h22, no rx_ack -> rx_data=8'h22, rx_valid=1, overrun=1; rx_ack 1 cycle -> rx_valid=0, overrun=0.
REQ-035 rst pulse during data bit 4 of 8'hFF, then full frame 8'h5A -> outputs zero after reset; then rx_data=8'h5A, rx_valid=1.
REQ-036 enable=0 with frame 8'h77 -> busy=0, rx_valid=0; enable dropped mid-frame 8'h77 -> rx_data=8'h77, rx_valid=1.
